// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: RV32M funct3 codes,
// FSM states and the fixed results returned by the divide special cases.
package muldiv_pkg;

    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Quotient for b == 0 and remainder for the signed overflow case; sliced to WIDTH
    localparam logic [MAX_WIDTH-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [MAX_WIDTH-1:0] OVERFLOW_REM  = '0;

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, op, a, b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op, a, b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring shift-subtract division step on unsigned magnitudes.
module muldiv_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic [WIDTH-1:0] quo_next_c
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, divisor};

    // rem < divisor keeps a non-negative diff below 2^WIDTH, so the top bit is the borrow
    always_comb begin
        rem_next_c = shifted[WIDTH-1:0];
        quo_next_c = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_next_c = diff[WIDTH-1:0];
            quo_next_c = {quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: iterative shift-add multiply and restoring divide.
// Build option MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int unsigned      PW       = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    op_e              op_in, op_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q, res_q;
    logic             neg_q, neg_r;

    logic             sign_a_in, sign_b_in, div_in, rem_in, div_zero, div_ovf, accept;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             skip_c;
    logic [WIDTH-1:0] skip_res;
    logic [WIDTH-1:0] div_rem, div_quo, hi_d, lo_d, fin_res;
    logic [WIDTH:0]   mul_sum;

    // Sign the full product, then pick the half the op asks for
    function automatic logic [WIDTH-1:0] mul_pick(op_e op, logic neg, logic [PW-1:0] p);
        logic [PW-1:0] p_s;
        p_s = neg ? PW'(-p) : p;
        return (op == OP_MUL) ? p_s[WIDTH-1:0] : p_s[PW-1:WIDTH];
    endfunction

    // Request decode: magnitudes and sign flags taken at accept
    assign op_in     = op_e'(bus.op);
    assign sign_a_in = bus.a[WIDTH-1] && (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign sign_b_in = bus.b[WIDTH-1] && (op_in inside {OP_MULH, OP_DIV, OP_REM});
    assign a_mag     = sign_a_in ? WIDTH'(-bus.a) : bus.a;
    assign b_mag     = sign_b_in ? WIDTH'(-bus.b) : bus.b;
    assign div_in    = op_in[2];
    assign rem_in    = op_in[2] & op_in[1];
    assign div_zero  = div_in && (bus.b == '0);
    assign div_ovf   = div_in && !op_in[0] && (bus.a == MIN_NEG) && (bus.b == '1);
    assign accept    = bus.in_valid && (state_q == ST_IDLE) && !bus.flush;

    // Operations resolved without iterating
    always_comb begin
        skip_c   = 1'b0;
        skip_res = '0;
        if (div_zero) begin
            skip_c   = 1'b1;
            skip_res = rem_in ? bus.a : DIV_BY_ZERO_Q[WIDTH-1:0];
        end else if (div_ovf) begin
            skip_c   = 1'b1;
            skip_res = rem_in ? OVERFLOW_REM[WIDTH-1:0] : bus.a;
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!div_in) begin
            skip_c   = 1'b1;
            skip_res = mul_pick(op_in, sign_a_in ^ sign_b_in, PW'(a_mag) * PW'(b_mag));
        end
`endif
    end

    muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem        (acc_hi_q),
        .quo        (acc_lo_q),
        .divisor    (opb_q),
        .rem_next_c (div_rem),
        .quo_next_c (div_quo)
    );

    assign mul_sum = (WIDTH+1)'(acc_hi_q) + (WIDTH+1)'(acc_lo_q[0] ? opb_q : '0);

    // Next accumulator pair and the signed result produced from it
    always_comb begin
        hi_d    = {mul_sum[WIDTH:1]};
        lo_d    = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        fin_res = '0;
        if (op_q[2]) begin
            hi_d    = div_rem;
            lo_d    = div_quo;
            fin_res = op_q[1] ? (neg_r ? WIDTH'(-hi_d) : hi_d)
                              : (neg_q ? WIDTH'(-lo_d) : lo_d);
        end else begin
            fin_res = mul_pick(op_q, neg_q, {hi_d, lo_d});
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = skip_c ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt_q == LAST_CNT) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    // Datapath registers; res_q is non-zero only while in DONE
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            op_q     <= OP_MUL;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            res_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (accept) begin
                    op_q     <= op_in;
                    cnt_q    <= '0;
                    neg_q    <= sign_a_in ^ sign_b_in;
                    neg_r    <= sign_a_in;
                    acc_hi_q <= '0;
                    acc_lo_q <= div_in ? a_mag : b_mag;
                    opb_q    <= div_in ? b_mag : a_mag;
                    if (skip_c) res_q <= skip_res;
                end
                ST_CALC: begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    acc_hi_q <= hi_d;
                    acc_lo_q <= lo_d;
                    if (cnt_q == LAST_CNT) res_q <= fin_res;
                end
                ST_DONE: if (bus.out_ready) res_q <= '0;
                default: res_q <= '0;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.result    = res_q;
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH)+1, iteration counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have ports a, b  input  WIDTH each  rs1 and rs2 operands.
REQ-009 SHALL have port flush  input  1  kill in-flight operation (pipeline squash).
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  selected result.
REQ-013 SHALL have port busy  output  1  high when state != IDLE (hazard-unit stall).

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-015 Request accepted when in_valid & in_ready at a rising edge; op, a, b latched then; later input changes ignored.
REQ-016 in_valid while busy SHALL be ignored (no queuing).
REQ-017 Signed ops SHALL convert operands to magnitude at accept, apply result sign at DONE entry; MULHSU treats a signed, b unsigned.
REQ-018 Multiply (iterative): CALC lasts exactly WIDTH cycles, one shift-add per cycle over a 2*WIDTH product; MUL returns low half, MULH* high half.
REQ-019 Divide: CALC lasts exactly WIDTH cycles, one restoring shift-subtract per cycle; quotient sign = sign(a)^sign(b), remainder sign = sign(a).
REQ-020 Divide-by-zero (b==0): skip CALC, enter DONE next cycle; DIV/DIVU result all-ones, REM/REMU result = a.
REQ-021 Signed overflow (DIV/REM, a = 1<<(WIDTH-1), b = all-ones): skip CALC; DIV result = a, REM result = 0.
REQ-022 out_valid = (state==DONE); result stable and held while out_valid & !out_ready.
REQ-023 out_valid & out_ready at an edge SHALL return to IDLE; new request acceptable the following cycle (no same-cycle turnaround).
REQ-024 Normal latency: accept edge to out_valid = WIDTH+1 cycles; special cases = 1 cycle.
REQ-025 flush SHALL force IDLE at the next edge from any state; no out_valid for the killed op; flush has priority over accept and out_ready.
REQ-026 result SHALL be 0 when out_valid is low.

Reset
REQ-027 reset SHALL force IDLE, counter 0, internal accumulators 0; in_ready=1, out_valid=0, busy=0, result=0 in the cycle after reset.
REQ-028 reset has priority over flush and all handshakes; reset mid-CALC discards the operation.

Configuration
REQ-029 Macro MULDIV_FAST_MUL_EN: defined -> MUL* skip CALC, product computed by single-cycle multiplier and registered into DONE (latency 1); undefined -> iterative multiply per REQ-018; divide behaviour identical in both builds.

Structure
REQ-030 Package muldiv_pkg SHALL hold op encodings, FSM state encodings, and special-case result constants.
REQ-031 Sub-module muldiv_div_step SHALL implement one combinational restoring shift-subtract step (partial remainder, quotient, divisor in; updated pair out), instantiated once.

Verification (WIDTH=32)
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> result 0xFFFFFFFD after 33 cycles; REM same operands -> 0xFFFFFFFF.
REQ-033 DIVU a=0x12345678, b=0 -> 0xFFFFFFFF after 1 cycle; REMU same -> 0x12345678.
REQ-034 DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0x00000000; both 1-cycle.
REQ-035 MULH a=b=0xFFFFFFFF -> 0x00000000; MULHU -> 0xFFFFFFFE; MUL -> 0x00000001; latency 33 (1 with MULDIV_FAST_MUL_EN).
REQ-036 DIVU 100/7 with out_ready low 5 cycles after out_valid -> result 0x0000000E held stable, busy=1, in_ready=0 throughout; IDLE one cycle after out_ready rises.
REQ-037 flush pulse 10 cycles into a DIV -> no out_valid, in_ready=1 next cycle; next DIVU 9/3 returns 0x00000003.
